// File: rtl/hit_score_tracker_pkg.sv
// score_pkg: shared types for the score-event producer and its consumers.
package score_pkg;
  typedef logic [1:0] hit_code_t;
  localparam hit_code_t HIT_NONE = 2'b00;
  localparam hit_code_t HIT_OBS1 = 2'b01;
  localparam hit_code_t HIT_OBS2 = 2'b10;
  localparam hit_code_t HIT_BOTH = 2'b11;
  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, EMIT, COOLDOWN} state_t;
  function automatic logic [6:0] bcd_value(bcd_t d1, bcd_t d0);
    return 7'(d1) * 7'd10 + 7'(d0);
  endfunction
endpackage

// File: rtl/hit_score_tracker_bcd_sat_adder2.sv
// bcd_sat_adder2: two-digit BCD plus a 2-bit increment, saturating at 99.
module bcd_sat_adder2
  import score_pkg::*;
(
  input  bcd_t       d0_i,
  input  bcd_t       d1_i,
  input  logic [1:0] inc_i,
  output bcd_t       s0_o,
  output bcd_t       s1_o
);
  logic [4:0] u;
  logic [4:0] t;
  logic       c;
  always_comb begin
    u = {1'b0, d0_i} + {3'b0, inc_i};
    c = u > 5'd9;
    t = {1'b0, d1_i} + {4'b0, c};
    s0_o = t > 5'd9 ? 4'd9 : (c ? 4'(u - 5'd10) : u[3:0]);
    s1_o = t > 5'd9 ? 4'd9 : t[3:0];
  end
endmodule

// File: rtl/hit_score_tracker.sv
// hit_score_tracker: per-frame ball/obstacle hit events, BCD score and level flags.
module hit_score_tracker
  import score_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int LEVEL1_TH       = 10,
  parameter int LEVEL2_TH       = 20
) (
  input  logic      clk,
  input  logic      resetN,
  input  logic      startOfFrame,
  input  logic      gameRestart,
  input  logic      ballDR,
  input  logic      obstacle1DR,
  input  logic      obstacle2DR,
  output hit_code_t obstacle_num,
  output bcd_t      scoreDigit0,
  output bcd_t      scoreDigit1,
  output logic      scoreLevel1,
  output logic      scoreLevel2
);
  localparam int CW = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  state_t    state_q, state_d;
  hit_code_t code_q, code_d, hit_q, hit_d, prev_q, prev_d, contact, code_new;
  logic [CW-1:0] cd_q, cd_d;
  bcd_t dig0_q, dig0_d, dig1_q, dig1_d, sum0, sum1;
  assign contact  = {ballDR & obstacle2DR, ballDR & obstacle1DR};
  assign code_new = hit_q & ~prev_q;
  bcd_sat_adder2 u_add (
    .d0_i (dig0_q),
    .d1_i (dig1_q),
    .inc_i(code_q),
    .s0_o (sum0),
    .s1_o (sum1)
  );
  always_comb begin
    hit_d        = (startOfFrame ? HIT_NONE : hit_q) | contact;
    prev_d       = startOfFrame ? hit_q : prev_q;
    state_d      = state_q;
    code_d       = code_q;
    cd_d         = cd_q;
    dig0_d       = dig0_q;
    dig1_d       = dig1_q;
    obstacle_num = HIT_NONE;
    case (state_q)
      IDLE: if (startOfFrame && code_new != HIT_NONE) begin
        state_d = EMIT;
        code_d  = code_new;
      end
      EMIT: begin
        obstacle_num = code_q;
        dig0_d       = sum0;
        dig1_d       = sum1;
        cd_d         = CW'(COOLDOWN_FRAMES);
        state_d      = COOLDOWN_FRAMES > 0 ? COOLDOWN : IDLE;
      end
      COOLDOWN: if (startOfFrame) begin
        cd_d    = cd_q - CW'(1);
        state_d = cd_q == CW'(1) ? IDLE : COOLDOWN;
      end
      default: state_d = IDLE;
    endcase
    // Restart clears state but leaves an in-flight EMIT pulse visible this cycle
    if (gameRestart) begin
      state_d = IDLE;
      code_d  = HIT_NONE;
      hit_d   = HIT_NONE;
      prev_d  = HIT_NONE;
      cd_d    = '0;
      dig0_d  = '0;
      dig1_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      code_q  <= HIT_NONE;
      hit_q   <= HIT_NONE;
      prev_q  <= HIT_NONE;
      cd_q    <= '0;
      dig0_q  <= '0;
      dig1_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      hit_q   <= hit_d;
      prev_q  <= prev_d;
      cd_q    <= cd_d;
      dig0_q  <= dig0_d;
      dig1_q  <= dig1_d;
    end
  assign scoreDigit0 = dig0_q;
  assign scoreDigit1 = dig1_q;
  assign scoreLevel1 = bcd_value(dig1_q, dig0_q) >= 7'(LEVEL1_TH);
  assign scoreLevel2 = bcd_value(dig1_q, dig0_q) >= 7'(LEVEL2_TH);
endmodule

// File: tb/tb_hit_score_tracker.sv
// tb_hit_score_tracker: directed checks on a no-cooldown and a 4-frame-cooldown instance.
module tb_hit_score_tracker;
  logic clk = 0, resetN = 0, sof = 0, gr = 0, ball = 0, obs1 = 0, obs2 = 0;
  logic [1:0] on0, on4, last0, last4;
  logic [3:0] a0, a1, b0, b1;
  logic l10, l20, l14, l24;
  logic [1:0] hist4 [0:63];
  int checks = 0, errors = 0, np0 = 0, np4 = 0, fi = 0;
  always #5 clk = ~clk;
  hit_score_tracker #(.COOLDOWN_FRAMES(0)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .gameRestart(gr), .ballDR(ball),
    .obstacle1DR(obs1), .obstacle2DR(obs2), .obstacle_num(on0), .scoreDigit0(a0),
    .scoreDigit1(a1), .scoreLevel1(l10), .scoreLevel2(l20));
  hit_score_tracker #(.COOLDOWN_FRAMES(4)) dut4 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .gameRestart(gr), .ballDR(ball),
    .obstacle1DR(obs1), .obstacle2DR(obs2), .obstacle_num(on4), .scoreDigit0(b0),
    .scoreDigit1(b1), .scoreLevel1(l14), .scoreLevel2(l24));
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic o1, input logic o2);
    @(negedge clk); sof = 1; ball = 0; obs1 = 0; obs2 = 0;
    @(negedge clk); sof = 0;
    last0 = on0; last4 = on4;
    np0 += int'(on0 != 0); np4 += int'(on4 != 0);
    fi++;
    if (fi < 64) hist4[fi] = on4;
    ball = o1 | o2; obs1 = o1; obs2 = o2;
    @(negedge clk); ball = 0; obs1 = 0; obs2 = 0;
    @(negedge clk);
  endtask
  task automatic restart();
    @(negedge clk); gr = 1;
    @(negedge clk); gr = 0;
    np0 = 0; np4 = 0; fi = 0;
  endtask
  initial begin
    #23;
    chk("rst_num0", on0, 0); chk("rst_num4", on4, 0);
    chk("rst_score0", {a1, a0}, 0); chk("rst_score4", {b1, b0}, 0);
    chk("rst_lvl0", {l20, l10}, 0); chk("rst_lvl4", {l24, l14}, 0);
    @(negedge clk); resetN = 1;
    frame(0, 1); frame(0, 0);
    chk("obs2_pulse0", last0, 2); chk("obs2_pulse4", last4, 2);
    chk("obs2_score0", {a1, a0}, 8'h02); chk("obs2_score4", {b1, b0}, 8'h02);
    frame(0, 0);
    chk("obs2_nopulse0", last0, 0); chk("obs2_nopulse4", last4, 0);
    restart();
    chk("restart_score4", {b1, b0}, 0);
    for (int i = 0; i < 10; i++) frame(1, 0);
    frame(0, 0);
    chk("cont_pulses0", np0, 1); chk("cont_pulses4", np4, 1);
    chk("cont_score0", {a1, a0}, 8'h01); chk("cont_score4", {b1, b0}, 8'h01);
    restart();
    frame(1, 1); frame(0, 0);
    chk("both_pulse0", last0, 3); chk("both_pulse4", last4, 3);
    chk("both_score0", {a1, a0}, 8'h03); chk("both_cnt0", np0, 1);
    restart();
    for (int i = 0; i < 49; i++) begin
      frame(0, 1); frame(0, 0);
      if (i == 3) begin chk("lvl_at8", {a1, a0, l20, l10}, 10'h020); end
      if (i == 4) begin chk("lvl_at10", {a1, a0, l20, l10}, 10'h041); end
      if (i == 8) begin chk("lvl_at18", {a1, a0, l20, l10}, 10'h061); end
      if (i == 9) begin chk("lvl_at20", {a1, a0, l20, l10}, 10'h083); end
    end
    chk("sat_98", {a1, a0}, 8'h98);
    frame(0, 1); frame(0, 0);
    chk("sat_99", {a1, a0}, 8'h99); chk("sat_lvl", {l20, l10}, 2'b11);
    frame(0, 1); frame(0, 0);
    chk("sat_hold99", {a1, a0}, 8'h99);
    restart();
    for (int i = 0; i < 6; i++) begin frame(1, 0); frame(0, 0); end
    frame(0, 0);
    chk("cd_pulses4", np4, 2); chk("cd_score4", {b1, b0}, 8'h02);
    chk("cd_pulses0", np0, 6); chk("cd_score0", {a1, a0}, 8'h06);
    chk("cd_s2", hist4[2], 1); chk("cd_s4", hist4[4], 0);
    chk("cd_s6", hist4[6], 0); chk("cd_s8", hist4[8], 1);
    restart();
    for (int i = 0; i < 4; i++) begin
      frame(1, 1);
      for (int j = 0; j < 5; j++) frame(0, 0);
    end
    frame(1, 1); frame(0, 0); frame(0, 0);
    chk("pre_rst_score4", {b1, b0, l14}, 9'h02B); chk("pre_rst_score0", {a1, a0}, 8'h15);
    @(negedge clk); #2 resetN = 0; #1;
    chk("async_score4", {b1, b0}, 0); chk("async_lvl4", {l24, l14}, 0);
    chk("async_score0", {a1, a0}, 0); chk("async_num4", on4, 0);
    @(negedge clk); resetN = 1;
    frame(1, 0); frame(0, 0);
    chk("post_rst_pulse4", last4, 1); chk("post_rst_score4", {b1, b0}, 8'h01);
    restart();
    frame(0, 1);
    @(negedge clk); sof = 1;
    @(negedge clk); sof = 0;
    chk("gr_emit_num0", on0, 2); chk("gr_emit_num4", on4, 2);
    gr = 1;
    @(negedge clk); gr = 0;
    chk("gr_score0", {a1, a0}, 0); chk("gr_score4", {b1, b0}, 0);
    chk("gr_num4", on4, 0);
    @(negedge clk);
    chk("gr_hold0", {a1, a0, l10}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
